// File: rtl/wb_regbank_writer.sv
// Writeback stage: selects the writeback value, updates the 16x32 register bank and flags,
// serves two bypassed decode read ports, and emits a registered forwarding record.
module wb_regbank_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NFLAGS = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic [ADDR_W-1:0] wb_WC,
  input  logic [DATA_W-1:0] wb_PC,
  input  logic [DATA_W-1:0] wb_PR,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [1:0]        wb_S_MXRB,
  input  logic              wb_W_RB,
  input  logic [NFLAGS-1:0] wb_W_RF,
  input  logic [NFLAGS-1:0] wb_flags,
  input  logic [ADDR_W-1:0] rd_RA,
  input  logic [ADDR_W-1:0] rd_RB,
  output logic [DATA_W-1:0] rd_A,
  output logic [DATA_W-1:0] rd_B,
  output logic [NFLAGS-1:0] flags,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_WC,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retire_cnt,
  output logic              err_sel
);

  localparam int NREGS = 1 << ADDR_W;

  typedef enum logic [1:0] {
    SEL_ALU     = 2'b00,
    SEL_MEM     = 2'b01,
    SEL_PC      = 2'b10,
    SEL_ILLEGAL = 2'b11
  } wb_sel_e;

  logic [DATA_W-1:0] bank [NREGS];
  logic [DATA_W-1:0] wb_data;
  logic              we;
  logic              sel_illegal;
  logic              retire;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    wb_data = '0;
    case (wb_sel_e'(wb_S_MXRB))
      SEL_ALU: wb_data = wb_alu_res;
      SEL_MEM: wb_data = wb_PR;
      SEL_PC:  wb_data = wb_PC;
      default: wb_data = '0;
    endcase
  end

  assign sel_illegal = ENABLE & wb_W_RB & (wb_S_MXRB == SEL_ILLEGAL);
  assign we          = ENABLE & wb_W_RB & (wb_S_MXRB != SEL_ILLEGAL);
  assign retire      = ENABLE & (we | (|wb_W_RF));

  // Write-through bypass: decode sees the value being written this cycle.
  assign rd_A = (we && rd_RA == wb_WC) ? wb_data : bank[rd_RA];
  assign rd_B = (we && rd_RB == wb_WC) ? wb_data : bank[rd_RB];

  // NOTE: the bank is reset because reads after reset must return zero; this keeps it in flops, not RAM.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else if (we) begin
      bank[wb_WC] <= wb_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags      <= '0;
      fwd_valid  <= 1'b0;
      fwd_WC     <= '0;
      fwd_data   <= '0;
      retire_cnt <= '0;
      err_sel    <= 1'b0;
    end else begin
      fwd_valid <= we;
      if (we) begin
        fwd_WC   <= wb_WC;
        fwd_data <= wb_data;
      end
      if (ENABLE) begin
        for (int i = 0; i < NFLAGS; i++)
          if (wb_W_RF[i]) flags[i] <= wb_flags[i];
      end
      if (retire)      retire_cnt <= retire_cnt + 32'd1;
      if (sel_illegal) err_sel    <= 1'b1;
    end
  end

endmodule
